uart_hex_logger: RTL and testbench
==================================

// Module: uart_hex_logger
// PURPOSE
//  Upstream feeder for the UART transmitter. Captures (addr,data) event strobes from the
//  debug tap, buffers them in a small FIFO and emits each one as ASCII text "AAAA:DD\r\n".
//  It drives the transmitter's ready/write byte interface and never violates it.
//  Provides a saturating drop counter for events lost to overflow.
// PARAMETERS
//  DEPTH_LOG2  3   FIFO depth is 2**DEPTH_LOG2 events (default 8), 24 bits each
// PORTS
//  clk         in   1   system clock; one clock domain
//  rst         in   1   asynchronous, active-high reset
//  evt_strobe  in   1   one-cycle event pulse; no backpressure (fire-and-forget)
//  evt_addr    in  16   event address, sampled with evt_strobe
//  evt_data    in   8   event data, sampled with evt_strobe
//  tx_ready    in   1   transmitter can accept a byte
//  tx_write    out  1   byte offer; a transfer happens when tx_write && tx_ready
//  tx_data     out  8   ASCII byte
//  busy        out  1   FIFO not empty or a line is in progress
//  drop_count  out  8   events dropped, saturates at 255
// BEHAVIOUR
//  Reset values: tx_write=0, tx_data=8'h00, busy=0, drop_count=0, FIFO empty, FSM IDLE.
//  Reset is async: all outputs reach their reset values while rst is high, including mid-line.
//  Push: on evt_strobe, store {addr,data} iff the registered count < 2**DEPTH_LOG2 at that edge.
//   A pop in the same cycle does not make room. A rejected push increments drop_count (sat).
//  FSM, IDLE: if FIFO is non-empty, pop the head into the line register, set idx=0, go to EMIT.
//   The pop does not wait for tx_ready.
//  FSM, EMIT: tx_write = tx_ready (combinational); tx_data = char(idx).
//   On tx_write && tx_ready: idx+1. A transfer at idx==8 returns to IDLE.
//   IDLE always lasts at least 1 cycle between lines.
//  char(idx): 0-3 = hex of addr[15:12], addr[11:8], addr[7:4], addr[3:0];
//   4 = 8'h3A ':'; 5-6 = hex of data[7:4], data[3:0]; 7 = 8'h0D; 8 = 8'h0A.
//  Hex digit: nibble 0-9 -> 8'h30+n; 10-15 -> 8'h41+(n-10) (uppercase).
//  tx_data is 8'h00 in IDLE.
//  Each char is offered until accepted, exactly once; tx_data is stable while tx_ready is low.
//  Ordering: lines leave in strobe order. Simultaneous push and pop are both legal.
//  The FIFO pointers wrap modulo depth; count width is DEPTH_LOG2+1.
//  busy = !empty || state==EMIT.
//  A reset mid-line abandons the line. A byte already inside the transmitter is its concern.
// STRUCTURE
//  Shared header uart_hex_pkg.vh holds:
//   - constants ASCII_COLON, ASCII_CR, ASCII_LF;
//   - function hex_ascii(nibble);
//   - FSM state encodings LOG_IDLE, LOG_EMIT.
//  Sub-module event_fifo (params WIDTH=24, DEPTH_LOG2): async-reset sync FIFO.
//   Ports: push/pop/din/dout/empty/full/count.
//   dout is valid while !empty (show-ahead).
//  Top level: FSM, 4-bit idx counter, 24-bit line register, char mux, drop counter.
// TESTING
//  Model the transmitter as accepting on tx_ready and then holding ready low for N cycles.
//  1 Single strobe, addr=16'hC80A data=8'h5F, tx_ready tied 1
//    -> bytes 43 38 30 41 3A 35 46 0D 0A, then tx_write=0, busy=0.
//  2 Same event; tx_ready low for 100 cycles after each accept
//    -> identical 9 bytes; exactly one tx_write&&tx_ready per byte; tx_data stable while waiting.
//  3 tx_ready=0; 10 strobes on consecutive cycles (default depth)
//    -> the first is popped at once; 9 lines later emitted in order; drop_count=1.
//  4 FIFO full and ready held low; 300 more strobes -> drop_count saturates at 8'hFF.
//  5 Assert rst after 4 chars of a line -> tx_write=0, busy=0 during rst.
//    New event after release -> full line from '0'-index char.
//  6 count==8 and a pop and a strobe in the same cycle -> strobe dropped, drop_count+1.
//    Strobe on the next cycle -> accepted.

Source files
------------

// File: rtl/uart_hex_logger_pkg.sv
// Shared definitions for the UART hex logger: ASCII constants, FSM encodings,
// the buffered event record and the nibble-to-ASCII helper.
// Ports: none (package).
package uart_hex_logger_pkg;

  localparam logic [7:0] ASCII_COLON = 8'h3A;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;

  // A line is "AAAA:DD\r\n": character indices 0..8.
  localparam logic [3:0] LAST_IDX = 4'd8;

  localparam int EVT_W = 24;

  typedef enum logic {
    LOG_IDLE = 1'b0,
    LOG_EMIT = 1'b1
  } log_state_t;

  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  data;
  } evt_t;

  // Uppercase hex digit for one nibble.
  function automatic logic [7:0] hex_ascii(input logic [3:0] nibble);
    logic [7:0] n8;
    n8 = {4'h0, nibble};
    if (nibble < 4'd10) begin
      return 8'h30 + n8;
    end
    return 8'h41 + (n8 - 8'd10);
  endfunction

endpackage

// File: rtl/uart_hex_logger_if.sv
// Event-tap and transmitter byte interface of the hex logger.
// master: the logger (consumes events and tx_ready, drives tx_write/tx_data).
// slave : the environment (debug tap + UART transmitter).
interface uart_hex_logger_if;
  logic        evt_strobe;
  logic [15:0] evt_addr;
  logic [7:0]  evt_data;
  logic        tx_ready;
  logic        tx_write;
  logic [7:0]  tx_data;

  modport master (
    input  evt_strobe, evt_addr, evt_data, tx_ready,
    output tx_write, tx_data
  );

  modport slave (
    output evt_strobe, evt_addr, evt_data, tx_ready,
    input  tx_write, tx_data
  );
endinterface

// File: rtl/uart_hex_logger_event_fifo.sv
// Synchronous show-ahead FIFO with async active-high reset.
// Latency: a push is visible on dout the cycle after; dout valid while !empty.
// Backpressure: push ignored when full, pop ignored when empty.
// Ports: clk, rst, push, pop, din[WIDTH], dout[WIDTH], empty, full, count[DEPTH_LOG2+1].
module event_fifo #(
  parameter int WIDTH      = 24,
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic [WIDTH-1:0]      din,
  output logic [WIDTH-1:0]      dout,
  output logic                  empty,
  output logic                  full,
  output logic [DEPTH_LOG2:0]   count
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic                  push_ok;
  logic                  pop_ok;

  // count never exceeds DEPTH, so its MSB alone means full.
  assign full    = count[DEPTH_LOG2];
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/uart_hex_logger.sv
// Buffers (addr,data) debug events and prints each as "AAAA:DD\r\n" to a UART transmitter.
// Latency: first byte offered two cycles after the strobe when idle; one IDLE cycle between lines.
// Backpressure: events are never stalled (overflow is counted); bytes wait on tx_ready.
// Ports: clk, rst; bus (master): evt_strobe/evt_addr/evt_data in, tx_ready in,
//        tx_write/tx_data out; busy out; drop_count[8] out (saturating).
module uart_hex_logger
  import uart_hex_logger_pkg::*;
#(
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  uart_hex_logger_if.master      bus,
  output logic                   busy,
  output logic [7:0]             drop_count
);

  localparam logic [DEPTH_LOG2:0] FIFO_DEPTH = (DEPTH_LOG2+1)'(1 << DEPTH_LOG2);

  log_state_t            state;
  logic [3:0]            idx;
  evt_t                  line;
  evt_t                  head;
  logic                  fifo_empty;
  logic                  fifo_full;
  logic [DEPTH_LOG2:0]   fifo_count;
  logic                  push;
  logic                  pop;
  logic                  xfer;
  logic [7:0]            char_sel;

  // Admission uses the registered count only, so a same-cycle pop never frees a slot.
  assign push = bus.evt_strobe && (fifo_count < FIFO_DEPTH);
  // The head is taken as soon as we are idle; it does not wait for tx_ready.
  assign pop  = (state == LOG_IDLE) && !fifo_empty;

  event_fifo #(
    .WIDTH      (EVT_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   ({bus.evt_addr, bus.evt_data}),
    .dout  (head),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (fifo_count)
  );

  // Offer follows tx_ready directly, so every offer is an accepted transfer.
  assign bus.tx_write = (state == LOG_EMIT) && bus.tx_ready;
  assign xfer         = bus.tx_write;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= LOG_IDLE;
      idx   <= '0;
      line  <= '0;
    end else begin
      case (state)
        LOG_IDLE: begin
          if (!fifo_empty) begin
            line  <= head;
            idx   <= '0;
            state <= LOG_EMIT;
          end
        end
        LOG_EMIT: begin
          if (xfer) begin
            if (idx == LAST_IDX) begin
              state <= LOG_IDLE;
            end else begin
              idx <= idx + 4'd1;
            end
          end
        end
        default: state <= LOG_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_count <= '0;
    end else if (bus.evt_strobe && fifo_full && (drop_count != 8'hFF)) begin
      drop_count <= drop_count + 8'd1;
    end
  end

  always_comb begin
    char_sel = 8'h00;
    case (idx)
      4'd0:    char_sel = hex_ascii(line.addr[15:12]);
      4'd1:    char_sel = hex_ascii(line.addr[11:8]);
      4'd2:    char_sel = hex_ascii(line.addr[7:4]);
      4'd3:    char_sel = hex_ascii(line.addr[3:0]);
      4'd4:    char_sel = ASCII_COLON;
      4'd5:    char_sel = hex_ascii(line.data[7:4]);
      4'd6:    char_sel = hex_ascii(line.data[3:0]);
      4'd7:    char_sel = ASCII_CR;
      4'd8:    char_sel = ASCII_LF;
      default: char_sel = 8'h00;
    endcase
  end

  // Derived only from registers, so it cannot move while tx_ready is low.
  assign bus.tx_data = (state == LOG_EMIT) ? char_sel : 8'h00;
  assign busy        = !fifo_empty || (state == LOG_EMIT);

endmodule

// File: tb/tb_uart_hex_logger.sv
module tb_uart_hex_logger;

  logic       clk;
  logic       rst;
  logic       busy;
  logic [7:0] drop_count;

  uart_hex_logger_if bus();

  uart_hex_logger #(.DEPTH_LOG2(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .busy       (busy),
    .drop_count (drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Transmitter model and byte monitor.
  logic [7:0] rxq[$];
  int         xfer_cnt = 0;
  int         hold_n   = 0;
  bit         ready_en = 0;
  bit         stab_en  = 0;
  int         stab_err = 0;

  // Transfers are sampled at the falling edge; inputs only change just after rising edges.
  initial begin
    logic       prev_ready;
    logic [7:0] prev_data;
    prev_ready = 1'b1;
    prev_data  = 8'h00;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_ready = 1'b1;
      end else begin
        if (bus.tx_write && bus.tx_ready) begin
          rxq.push_back(bus.tx_data);
          xfer_cnt++;
        end
        if (stab_en && !prev_ready && !bus.tx_ready && prev_data != 8'h00 &&
            bus.tx_data != prev_data)
          stab_err++;
        prev_ready = bus.tx_ready;
        prev_data  = bus.tx_data;
      end
    end
  end

  initial begin
    int hold;
    int last;
    hold = 0;
    last = 0;
    bus.tx_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (xfer_cnt != last) begin
        last = xfer_cnt;
        hold = hold_n;
      end else if (hold > 0) begin
        hold--;
      end
      bus.tx_ready = ready_en && (hold == 0);
    end
  end

  function automatic logic [7:0] hexc(input logic [3:0] n);
    return (n < 4'd10) ? (8'd48 + 8'(n)) : (8'd55 + 8'(n));
  endfunction

  function automatic logic [7:0] exp_char(input logic [23:0] ev, input int i);
    case (i)
      0: return hexc(ev[23:20]);
      1: return hexc(ev[19:16]);
      2: return hexc(ev[15:12]);
      3: return hexc(ev[11:8]);
      4: return 8'h3A;
      5: return hexc(ev[7:4]);
      6: return hexc(ev[3:0]);
      7: return 8'h0D;
      default: return 8'h0A;
    endcase
  endfunction

  function automatic logic [23:0] ev_of(input int i);
    return {16'(16'hA000 + i * 273), 8'(i * 27 + 1)};
  endfunction

  task automatic check_lines(input string tag, input logic [23:0] evs[$]);
    chk({tag, " nbytes"}, rxq.size(), evs.size() * 9);
    for (int l = 0; l < evs.size(); l++)
      for (int c = 0; c < 9; c++)
        if (l * 9 + c < rxq.size())
          chk($sformatf("%s l%0d c%0d", tag, l, c), rxq[l*9+c], exp_char(evs[l], c));
    rxq.delete();
  endtask

  task automatic wait_idle(input string tag, input int max);
    int n;
    n = 0;
    repeat (2) @(posedge clk);
    #1;
    while (busy && n < max) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({tag, " idle"}, busy, 0);
  endtask

  task automatic wait_xfer(input string tag, input int target, input int max);
    int n;
    n = 0;
    while (xfer_cnt < target && n < max) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({tag, " xfers"}, 32'(xfer_cnt >= target), 1);
  endtask

  task automatic strobe_on(input logic [23:0] ev);
    bus.evt_strobe = 1'b1;
    bus.evt_addr   = ev[23:8];
    bus.evt_data   = ev[7:0];
  endtask

  task automatic send(input logic [23:0] ev);
    strobe_on(ev);
    @(posedge clk);
    #1;
    bus.evt_strobe = 1'b0;
  endtask

  initial begin
    logic [7:0]  exp1 [9];
    logic [23:0] evs[$];
    int          base;

    exp1 = '{8'h43, 8'h38, 8'h30, 8'h41, 8'h3A, 8'h35, 8'h46, 8'h0D, 8'h0A};
    rst = 1'b1;
    bus.evt_strobe = 1'b0;
    bus.evt_addr   = 16'h0;
    bus.evt_data   = 8'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst tx_write", bus.tx_write, 0);
    chk("rst tx_data", bus.tx_data, 8'h00);
    chk("rst busy", busy, 0);
    chk("rst drop", drop_count, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // 1: single event, ready tied high
    ready_en = 1;
    hold_n   = 0;
    repeat (2) @(posedge clk);
    #1;
    send(24'hC80A5F);
    wait_idle("t1", 100);
    chk("t1 nbytes", rxq.size(), 9);
    for (int i = 0; i < 9; i++)
      if (i < rxq.size()) chk($sformatf("t1 byte%0d", i), rxq[i], exp1[i]);
    chk("t1 tx_write", bus.tx_write, 0);
    rxq.delete();

    // 2: slow transmitter, 100 cycles not-ready after each accept
    hold_n  = 100;
    stab_en = 1;
    send(24'hC80A5F);
    wait_idle("t2", 2000);
    chk("t2 nbytes", rxq.size(), 9);
    for (int i = 0; i < 9; i++)
      if (i < rxq.size()) chk($sformatf("t2 byte%0d", i), rxq[i], exp1[i]);
    chk("t2 stable", stab_err, 0);
    stab_en = 0;
    rxq.delete();

    // 3: ready low, 10 back-to-back strobes
    hold_n   = 0;
    ready_en = 0;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 10; i++) begin
      strobe_on(ev_of(i));
      @(posedge clk);
      #1;
    end
    bus.evt_strobe = 1'b0;
    chk("t3 drop", drop_count, 1);
    chk("t3 busy", busy, 1);
    chk("t3 no write", bus.tx_write, 0);
    ready_en = 1;
    wait_idle("t3", 1000);
    evs.delete();
    for (int i = 0; i < 9; i++) evs.push_back(ev_of(i));
    check_lines("t3", evs);

    // 4: FIFO full, ready low, 300 extra strobes saturate the drop counter
    ready_en = 0;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 9; i++) begin
      strobe_on(ev_of(i + 20));
      @(posedge clk);
      #1;
    end
    chk("t4 drop full", drop_count, 1);
    for (int i = 0; i < 300; i++) begin
      strobe_on(24'hFFFF00);
      @(posedge clk);
      #1;
      if (i == 252) chk("t4 drop 254", drop_count, 254);
    end
    bus.evt_strobe = 1'b0;
    chk("t4 drop sat", drop_count, 8'hFF);
    ready_en = 1;
    wait_idle("t4", 1000);
    evs.delete();
    for (int i = 0; i < 9; i++) evs.push_back(ev_of(i + 20));
    check_lines("t4", evs);
    chk("t4 drop hold", drop_count, 8'hFF);

    // 5: reset after 4 characters of a line
    base = xfer_cnt;
    send(24'h12349A);
    wait_xfer("t5", base + 4, 100);
    rst = 1'b1;
    #1;
    chk("t5 rst tx_write", bus.tx_write, 0);
    chk("t5 rst busy", busy, 0);
    chk("t5 rst drop", drop_count, 0);
    chk("t5 rst data", bus.tx_data, 8'h00);
    chk("t5 partial", rxq.size(), 4);
    repeat (2) @(posedge clk);
    #1;
    chk("t5 rst hold write", bus.tx_write, 0);
    rst = 1'b0;
    rxq.delete();
    @(posedge clk);
    #1;
    send(24'hBEEF01);
    wait_idle("t5", 100);
    evs.delete();
    evs.push_back(24'hBEEF01);
    check_lines("t5", evs);

    // 6: strobe in the pop cycle with count==8 is dropped; next cycle accepted
    ready_en = 0;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 9; i++) begin
      strobe_on(ev_of(i + 40));
      @(posedge clk);
      #1;
    end
    bus.evt_strobe = 1'b0;
    chk("t6 drop pre", drop_count, 0);
    base     = xfer_cnt;
    ready_en = 1;
    wait_xfer("t6", base + 9, 200);
    strobe_on(24'h0BAD00);
    @(posedge clk);
    #1;
    chk("t6 drop edge", drop_count, 1);
    strobe_on(24'h600D77);
    @(posedge clk);
    #1;
    bus.evt_strobe = 1'b0;
    chk("t6 drop next", drop_count, 1);
    wait_idle("t6", 1000);
    evs.delete();
    for (int i = 0; i < 9; i++) evs.push_back(ev_of(i + 40));
    evs.push_back(24'h600D77);
    check_lines("t6", evs);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
